// File: rtl/mult_cs_tree.sv
// mult_cs_tree: WIDTH x WIDTH multiplier that returns its product in carry-save form.
// The product is (sum + carry) mod 2^(2*WIDTH). tc=1 treats a and b as two's
// complement, using Baugh-Wooley inversion plus a constant correction. tc=0
// treats them as unsigned.
// The partial-product columns are reduced by a Wallace tree of 3:2 counters
// until every column holds at most two bits. No carry-propagate adder is used.
// Optional macro MULT_CS_PIPE_EN registers sum/carry (1-cycle latency,
// asynchronous active-high reset). Without it the block is purely combinational.
module mult_cs_tree #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 tc,
    output logic [2*WIDTH-1:0]   sum,
    output logic [2*WIDTH-1:0]   carry
);

    localparam int W2     = 2 * WIDTH;
    // Tallest column is WIDTH bits (column WIDTH-1, or column WIDTH with the
    // correction bit). A reduction stage never grows a column past that,
    // so two slots of slack are plenty.
    localparam int MAXH   = WIDTH + 2;
    localparam int MAXSTG = W2;

    typedef logic [MAXH-1:0] col_t;

    logic [WIDTH-1:0] pp_row [WIDTH];
    col_t             col_v  [W2];
    col_t             nxt_v  [W2];
    int               cnt    [W2];
    int               ncnt   [W2];
    logic [W2-1:0]    sum_d;
    logic [W2-1:0]    carry_d;

    // Row gi holds a & b[gi]. In tc mode, a bit involving exactly one MSB is inverted.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pp
            localparam logic [WIDTH-1:0] INV_MASK = (gi == WIDTH - 1) ?
                {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
            assign pp_row[gi] = (a & {WIDTH{b[gi]}}) ^ (INV_MASK & {WIDTH{tc}});
        end
    endgenerate

    // Build the bit columns, then apply Wallace 3:2 layers until every column holds at most two bits.
    // Column heights depend only on WIDTH, so every loop unrolls to fixed wiring.
    always_comb begin
        int   nfa;
        logic busy;
        logic fx, fy, fz;

        for (int c = 0; c < W2; c++) begin
            col_v[c] = '0;
            nxt_v[c] = '0;
            cnt[c]   = 0;
            ncnt[c]  = 0;
        end
        nfa  = 0;
        busy = 1'b0;
        fx   = 1'b0;
        fy   = 1'b0;
        fz   = 1'b0;

        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                col_v[i+j][cnt[i+j]] = pp_row[i][j];
                cnt[i+j] = cnt[i+j] + 1;
            end
        end
        // Baugh-Wooley correction constant 2^N + 2^(2N-1), present only in tc mode.
        col_v[WIDTH][cnt[WIDTH]] = tc;
        cnt[WIDTH] = cnt[WIDTH] + 1;
        col_v[W2-1][cnt[W2-1]] = tc;
        cnt[W2-1] = cnt[W2-1] + 1;

        for (int s = 0; s < MAXSTG; s++) begin
            busy = 1'b0;
            for (int c = 0; c < W2; c++) begin
                busy = busy | (cnt[c] > 2);
            end
            if (busy) begin
                for (int c = 0; c < W2; c++) begin
                    nxt_v[c] = '0;
                    ncnt[c]  = 0;
                end
                for (int c = 0; c < W2; c++) begin
                    nfa = cnt[c] / 3;
                    for (int f = 0; f < MAXH / 3; f++) begin
                        if (f < nfa) begin
                            fx = col_v[c][3*f];
                            fy = col_v[c][3*f+1];
                            fz = col_v[c][3*f+2];
                            nxt_v[c][ncnt[c]] = fx ^ fy ^ fz;
                            ncnt[c] = ncnt[c] + 1;
                            // Carries out of the top column are dropped; the result is modulo 2^(2N).
                            if (c + 1 < W2) begin
                                nxt_v[c+1][ncnt[c+1]] = (fx & fy) | (fx & fz) | (fy & fz);
                                ncnt[c+1] = ncnt[c+1] + 1;
                            end
                        end
                    end
                    // Bits left over after the triplets pass through unchanged.
                    for (int k = 0; k < MAXH; k++) begin
                        if ((k >= 3 * nfa) && (k < cnt[c])) begin
                            nxt_v[c][ncnt[c]] = col_v[c][k];
                            ncnt[c] = ncnt[c] + 1;
                        end
                    end
                end
                for (int c = 0; c < W2; c++) begin
                    col_v[c] = nxt_v[c];
                    cnt[c]   = ncnt[c];
                end
            end
        end

        // Unused slots are zero, so the two rows can be read directly.
        for (int c = 0; c < W2; c++) begin
            sum_d[c]   = col_v[c][0];
            carry_d[c] = col_v[c][1];
        end
    end

`ifdef MULT_CS_PIPE_EN
    logic [W2-1:0] sum_q;
    logic [W2-1:0] carry_q;

    // Output register: capture every cycle; reset clears both vectors immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;
`else
    // Clock and reset are part of the port list but have no function in this build.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;

    assign sum   = sum_d;
    assign carry = carry_d;
`endif

endmodule

// File: tb/tb_mult_cs_tree.sv
// Testbench for mult_cs_tree. It instantiates WIDTH=16 and WIDTH=8 copies,
// uses directed vectors with literal products, and runs a random stream checked each cycle.
// The same bench covers the MULT_CS_PIPE_EN build when that macro is defined.
module tb_mult_cs_tree;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        tc    = 1'b0;
    logic [31:0] sum, carry;
    logic [15:0] sum8, carry8;
    logic [31:0] cs16;
    logic [15:0] cs8;
    logic [63:0] e16, e8;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    assign cs16 = sum + carry;
    assign cs8  = sum8 + carry8;

    always #5 clk = ~clk;

    mult_cs_tree #(.WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset), .a(a), .b(b), .tc(tc), .sum(sum), .carry(carry)
    );

    mult_cs_tree #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .a(a[7:0]), .b(b[7:0]), .tc(tc), .sum(sum8), .carry(carry8)
    );

    // Reference product: extend each operand to an integer, multiply, keep 2*w bits.
    function automatic logic [63:0] mref(input logic [15:0] x, input logic [15:0] y,
                                         input logic t, input int w);
        longint xv, yv, p;
        logic [63:0] mask;
        xv = 0;
        yv = 0;
        for (int k = 0; k < w; k++) begin
            xv = xv | (longint'(x[k]) << k);
            yv = yv | (longint'(y[k]) << k);
        end
        if (t && x[w-1]) xv = xv - (longint'(1) << w);
        if (t && y[w-1]) yv = yv - (longint'(1) << w);
        p    = xv * yv;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 64'(p) & mask;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (a=%h b=%h tc=%0d t=%0t)",
                     name, act, exp, a, b, tc, $time);
        end
    endtask

`ifdef MULT_CS_PIPE_EN
    logic [63:0] exp16_q, exp8_q;
    // Expected pipeline contents: the inputs sampled at each edge; reset clears them.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            exp16_q <= '0;
            exp8_q  <= '0;
        end else begin
            exp16_q <= mref(a, b, tc, 16);
            exp8_q  <= mref(a, b, tc, 8);
        end
    end
`endif

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
`ifdef MULT_CS_PIPE_EN
            e16 = exp16_q;
            e8  = exp8_q;
`else
            e16 = mref(a, b, tc, 16);
            e8  = mref(a, b, tc, 8);
`endif
            check("cycle_w16", 64'(cs16), e16);
            check("cycle_w8",  64'(cs8),  e8);
        end
    end

    task automatic apply(input logic [15:0] x, input logic [15:0] y, input logic t);
        @(posedge clk);
        #1;
        a  = x;
        b  = y;
        tc = t;
    endtask

    task automatic directed(input string name, input logic [15:0] x, input logic [15:0] y,
                            input logic t, input logic [31:0] lit);
        check({name, "_model"}, mref(x, y, t, 16), 64'(lit));
        apply(x, y, t);
`ifdef MULT_CS_PIPE_EN
        @(posedge clk);
`endif
        @(negedge clk);
        #1;
        check(name, 64'(cs16), 64'(lit));
        $display("txn %s a=%h b=%h tc=%0d sum+carry=%h", name, x, y, t, cs16);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
`ifdef MULT_CS_PIPE_EN
        check("reset_sum",   64'(sum),   64'd0);
        check("reset_carry", 64'(carry), 64'd0);
`endif
        reset  = 1'b0;
        cmp_en = 1'b1;

        directed("u_1234x5678", 16'h1234, 16'h5678, 1'b0, 32'h06260060);
        directed("s_1234x5678", 16'h1234, 16'h5678, 1'b1, 32'h06260060);
        directed("u_ffffxffff", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        directed("s_ffffxffff", 16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001);
        directed("s_8000x0001", 16'h8000, 16'h0001, 1'b1, 32'hFFFF8000);
        directed("u_8000x0001", 16'h8000, 16'h0001, 1'b0, 32'h00008000);
        directed("u_8000x8000", 16'h8000, 16'h8000, 1'b0, 32'h40000000);
        directed("s_8000x8000", 16'h8000, 16'h8000, 1'b1, 32'h40000000);
        directed("u_0000xbeef", 16'h0000, 16'hBEEF, 1'b0, 32'h00000000);
        directed("s_0000xbeef", 16'h0000, 16'hBEEF, 1'b1, 32'h00000000);
        directed("u_0001xbeef", 16'h0001, 16'hBEEF, 1'b0, 32'h0000BEEF);
        directed("s_0001xbeef", 16'h0001, 16'hBEEF, 1'b1, 32'hFFFFBEEF);

        for (int n = 0; n < 10000; n++) begin
            apply(16'($urandom), 16'($urandom), 1'($urandom));
        end
        $display("txn random_stream vectors=10000");

`ifdef MULT_CS_PIPE_EN
        // Asynchronous reset: outputs clear before any further clock edge.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_sum",   64'(sum),   64'd0);
        check("async_rst_carry", 64'(carry), 64'd0);
        $display("txn async_reset sum=%h carry=%h", sum, carry);

        // After release, a new operand appears only after the next edge.
        @(posedge clk);
        #1;
        reset = 1'b0;
        a     = 16'h0003;
        b     = 16'h0005;
        tc    = 1'b0;
        #1;
        check("hold_before_edge", 64'(cs16), 64'd0);
        @(posedge clk);
        #1;
        check("first_after_release", 64'(cs16), 64'h0000000F);
        $display("txn release_3x5 sum+carry=%h", cs16);

        // Mid-stream reset drops the captured product immediately.
        apply(16'h1234, 16'h5678, 1'b0);
        apply(16'hFFFF, 16'hFFFF, 1'b1);
        check("stream_prev", 64'(cs16), 64'h06260060);
        #1;
        reset = 1'b1;
        #1;
        check("midstream_rst", 64'(cs16), 64'd0);
        check("midstream_rst_sum", 64'(sum), 64'd0);
        $display("txn midstream_reset sum+carry=%h", cs16);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(16'h0001, 16'hBEEF, 1'b1);
        @(posedge clk);
        #1;
        check("after_midstream", 64'(cs16), 64'hFFFFBEEF);
`endif

        @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_cs_tree.md
Name: mult_cs_tree

Overview:
- Parameterized N×N multiplier that returns the product in carry-save form: two 2N-bit vectors whose modulo-2^(2N) sum equals the product.
- Supports unsigned operands and two's-complement operands, selected by a run-time mode input.
- Front end of the multiply datapath. The final carry-propagate add (sum+carry) is done downstream, so the block contains no full-width CPA.

Parameters:
- WIDTH, 16, operand width N in bits; WIDTH ≥ 4. Outputs are 2*WIDTH bits.

Ports:
- clk  input  1  clock; used only when the pipeline feature is compiled in.
- reset  input  1  asynchronous, active-high reset; used only when the pipeline feature is compiled in.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- tc  input  1  mode select: 1 = a and b are two's complement, 0 = unsigned.
- sum  output  2*WIDTH  carry-save sum vector.
- carry  output  2*WIDTH  carry-save carry vector, already aligned to bit weight; no further shift is needed.

Interface (already decided):
- One clock; reset is asynchronous and active-high.

Behaviour:
- Correctness invariant: (sum + carry) mod 2^(2*WIDTH) equals the product.
  - tc=0: zero-extend a and b.
  - tc=1: sign-extend a and b.
- Default build is purely combinational, zero latency. clk and reset have no effect on the outputs.
- Partial products: WIDTH rows of a[i]&b[j].
- tc=1 uses Baugh-Wooley handling:
  - Invert partial-product bits that involve exactly one MSB (a[N-1] or b[N-1], not both).
  - Add constant correction bits at weight 2^N and 2^(2N-1).
  - The correction constant is gated by tc.
  - The inverting XOR on the affected bits is gated by tc.
- Reduction:
  - Wallace tree of 3:2 full-adder (CSA) layers, column-wise.
  - Half adders are allowed where a column has 2 leftover bits.
  - Continue until every column holds ≤ 2 bits; those two rows form sum and carry.
- Bits carried out of column 2N-1 are discarded (modulo arithmetic).
- The individual values of sum and carry are implementation-defined. Only their modulo sum is architectural.
- No X propagation: any fully known a, b, tc produces fully known outputs.
- Edge cases that must satisfy the invariant:
  - a or b = 0 → product 0.
  - Most-negative × most-negative with tc=1.
  - All-ones operands in both modes.
- Changing tc alone must change the result accordingly, combinationally.

Optional Feature:
- Macro: MULT_CS_PIPE_EN.
- When defined:
  - sum and carry are registered on posedge clk; latency is exactly 1 cycle.
  - A new operand set is accepted every cycle (throughput 1 per clock).
  - reset asynchronously forces sum=0 and carry=0 (their sum is 0).
  - When reset is released, capture resumes at the next posedge.
  - Reset asserted mid-stream clears the outputs immediately. The in-flight operation is lost.
- When undefined:
  - Combinational as described in Behaviour; no state elements.
  - clk and reset are present but unused.

Test Plan:
- tc=0, a=0x1234, b=0x5678 → sum+carry = 0x06260060. tc=1 with the same operands → 0x06260060.
- tc=0, a=0xFFFF, b=0xFFFF → 0xFFFE0001. tc=1 with the same operands → 0x00000001.
- a=0x8000, b=0x0001:
  - tc=1 → 0xFFFF8000.
  - tc=0 → 0x00008000.
  - a=0x8000, b=0x8000 in both modes → 0x40000000.
- a=0x0000, b=0xBEEF in both modes → 0x00000000. a=0x0001, b=0xBEEF, tc=0 → 0x0000BEEF; tc=1 → 0xFFFFBEEF.
- 10,000 random a, b, tc vectors → invariant holds against a reference model (tc=0: {a}*{b}; tc=1: $signed(a)*$signed(b)), truncated to 32 bits. Zero mismatches; also run with WIDTH=8.
- With MULT_CS_PIPE_EN:
  - Assert reset → sum=carry=0 with no clock edge.
  - Release reset, drive a=0x0003, b=0x0005 → outputs stay 0 until the next posedge, then sum+carry=0x0000000F.
  - Back-to-back vectors each appear exactly one cycle later.
  - Reset asserted mid-stream clears the outputs asynchronously.
